stream_seq_checker: RTL and testbench

//  Receive-side checker for the WIDTH-bit data stream the counter stimulus drives through top.

---
 rtl/seq_chk_pkg.sv | 12 +
 rtl/sat_counter.sv | 25 ++
 rtl/stream_seq_checker.sv | 142 ++++++++++++++
 tb/tb_stream_seq_checker.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_chk_pkg.sv
// Shared types for the stream sequence checker.
// Holds the checker FSM state encoding used by stream_seq_checker.
package seq_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2,
        LOST   = 2'd3
    } seq_chk_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
// Used by stream_seq_checker for the word and error counts.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_value
);

    logic [W-1:0] r_value;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_value <= '0;
        end else if (i_inc && (r_value != {W{1'b1}})) begin
            r_value <= r_value + 1'b1;
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/stream_seq_checker.sv
// Receive-side checker that locks onto an incrementing WIDTH-bit stream and flags breaks.
// Define SEQ_CHK_AUTO_RESYNC_EN to make LOST fall back to SYNC on its own instead of sticking.
module stream_seq_checker
    import seq_chk_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int CNT_WIDTH   = 16,
    parameter int LOSS_THRESH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic                 i_valid,
    input  logic [WIDTH-1:0]     i_data,
    output logic                 o_locked,
    output logic                 o_err,
    output logic [CNT_WIDTH-1:0] o_err_cnt,
    output logic [CNT_WIDTH-1:0] o_word_cnt,
    output logic [WIDTH-1:0]     o_expected
);

    localparam int MISS_W = (LOSS_THRESH < 2) ? 1 : $clog2(LOSS_THRESH + 1);
    localparam logic [MISS_W-1:0] LOSS_LAST = MISS_W'(LOSS_THRESH - 1);

    seq_chk_state_t    r_state, w_state_nxt;
    logic              r_locked, w_locked_nxt;
    logic              r_err, w_err_nxt;
    logic [WIDTH-1:0]  r_expected, w_expected_nxt;
    logic [MISS_W-1:0] r_miss_run, w_miss_run_nxt;
    logic              w_err_inc;
    logic              w_word_inc;
    logic              w_cnt_clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
            r_expected <= '0;
            r_miss_run <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_locked   <= w_locked_nxt;
            r_err      <= w_err_nxt;
            r_expected <= w_expected_nxt;
            r_miss_run <= w_miss_run_nxt;
        end
    end

    // i_start takes priority over any word in the same cycle; that word is dropped uncounted.
    always_comb begin
        w_state_nxt    = r_state;
        w_locked_nxt   = r_locked;
        w_err_nxt      = 1'b0;
        w_expected_nxt = r_expected;
        w_miss_run_nxt = r_miss_run;
        w_err_inc      = 1'b0;
        w_word_inc     = 1'b0;
        w_cnt_clr      = 1'b0;

        if (i_start) begin
            w_cnt_clr      = 1'b1;
            w_locked_nxt   = 1'b0;
            w_miss_run_nxt = '0;
            w_state_nxt    = SYNC;
        end else begin
            case (r_state)
                IDLE: begin
                end
                SYNC: begin
                    if (i_valid) begin
                        w_expected_nxt = i_data + 1'b1;
                        w_word_inc     = 1'b1;
                        w_locked_nxt   = 1'b1;
                        w_miss_run_nxt = '0;
                        w_state_nxt    = LOCKED;
                    end
                end
                LOCKED: begin
                    if (i_valid) begin
                        w_word_inc = 1'b1;
                        if (i_data == r_expected) begin
                            w_expected_nxt = r_expected + 1'b1;
                            w_miss_run_nxt = '0;
                        end else begin
                            w_err_nxt      = 1'b1;
                            w_err_inc      = 1'b1;
                            w_expected_nxt = i_data + 1'b1;
                            w_miss_run_nxt = r_miss_run + 1'b1;
                            if (r_miss_run >= LOSS_LAST) begin
                                w_locked_nxt = 1'b0;
                                w_state_nxt  = LOST;
                            end
                        end
                    end
                end
                LOST: begin
`ifdef SEQ_CHK_AUTO_RESYNC_EN
                    // A word arriving during the single LOST cycle is taken as the new sync point.
                    if (i_valid) begin
                        w_expected_nxt = i_data + 1'b1;
                        w_word_inc     = 1'b1;
                        w_locked_nxt   = 1'b1;
                        w_miss_run_nxt = '0;
                        w_state_nxt    = LOCKED;
                    end else begin
                        w_state_nxt    = SYNC;
                    end
`else
                    if (i_valid) begin
                        w_word_inc = 1'b1;
                    end
`endif
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_WIDTH)) u_err_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_err_inc),
        .o_value (o_err_cnt)
    );

    sat_counter #(.W(CNT_WIDTH)) u_word_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_word_inc),
        .o_value (o_word_cnt)
    );

    assign o_locked   = r_locked;
    assign o_err      = r_err;
    assign o_expected = r_expected;

endmodule

// File: tb/tb_stream_seq_checker.sv
// Scoreboard bench for stream_seq_checker: a reference model pushes per-cycle expectations, checked #1 after each edge.
// Expectations for the loss scenario follow SEQ_CHK_AUTO_RESYNC_EN when it is defined.
module tb_stream_seq_checker;
    import seq_chk_pkg::*;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic        i_valid;
    logic [7:0]  i_data;

    logic        a_locked, a_err;
    logic [15:0] a_err_cnt, a_word_cnt;
    logic [7:0]  a_expected;

    logic        b_locked, b_err;
    logic [3:0]  b_err_cnt, b_word_cnt;
    logic [7:0]  b_expected;

    int checks = 0;
    int errors = 0;
    int errPulses = 0;

    typedef struct packed {
        logic        locked;
        logic        err;
        logic [15:0] errc;
        logic [15:0] wordc;
        logic [7:0]  exp;
    } exp_t;

    exp_t sb[$];

    seq_chk_state_t mState;
    exp_t           m;
    int             mMiss;

    stream_seq_checker #(.WIDTH(8), .CNT_WIDTH(16), .LOSS_THRESH(3)) dutA (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_locked   (a_locked),
        .o_err      (a_err),
        .o_err_cnt  (a_err_cnt),
        .o_word_cnt (a_word_cnt),
        .o_expected (a_expected)
    );

    stream_seq_checker #(.WIDTH(8), .CNT_WIDTH(4), .LOSS_THRESH(255)) dutB (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_locked   (b_locked),
        .o_err      (b_err),
        .o_err_cnt  (b_err_cnt),
        .o_word_cnt (b_word_cnt),
        .o_expected (b_expected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model of one clock edge for dutA (LOSS_THRESH 3, 16-bit counters).
    task automatic modelEdge(input logic s, input logic v, input logic r, input logic [7:0] d);
        logic lockNow;
        m.err = 1'b0;
        if (r) begin
            m = '0;
            mMiss = 0;
            mState = IDLE;
        end else if (s) begin
            m.errc = '0;
            m.wordc = '0;
            m.locked = 1'b0;
            mMiss = 0;
            mState = SYNC;
        end else if (v) begin
            lockNow = 1'b0;
            if (mState == SYNC) lockNow = 1'b1;
`ifdef SEQ_CHK_AUTO_RESYNC_EN
            if (mState == LOST) lockNow = 1'b1;
`endif
            if (lockNow) begin
                m.exp = d + 8'd1;
                if (m.wordc != 16'hFFFF) m.wordc = m.wordc + 16'd1;
                m.locked = 1'b1;
                mMiss = 0;
                mState = LOCKED;
            end else if (mState == LOCKED) begin
                if (m.wordc != 16'hFFFF) m.wordc = m.wordc + 16'd1;
                if (d == m.exp) begin
                    m.exp = m.exp + 8'd1;
                    mMiss = 0;
                end else begin
                    m.err = 1'b1;
                    if (m.errc != 16'hFFFF) m.errc = m.errc + 16'd1;
                    m.exp = d + 8'd1;
                    mMiss = mMiss + 1;
                    if (mMiss >= 3) begin
                        m.locked = 1'b0;
                        mState = LOST;
                    end
                end
            end else if (mState == LOST) begin
                if (m.wordc != 16'hFFFF) m.wordc = m.wordc + 16'd1;
            end
        end else begin
`ifdef SEQ_CHK_AUTO_RESYNC_EN
            if (mState == LOST) mState = SYNC;
`endif
        end
    endtask

    // Drive one cycle, push the model's expectation, then pop and compare after the edge.
    task automatic step(input logic s, input logic v, input logic r, input logic [7:0] d);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst = r;
        i_start = s;
        i_valid = v;
        i_data = d;
        modelEdge(s, v, r, d);
        sb.push_back(m);
        @(posedge clk);
        #1;
        got = {a_locked, a_err, a_err_cnt, a_word_cnt, a_expected};
        if (a_err) errPulses++;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard empty at t=%0t", $time);
        end else begin
            e = sb.pop_front();
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL scoreboard t=%0t got locked=%b err=%b errc=%0d wordc=%0d exp=%h want locked=%b err=%b errc=%0d wordc=%0d exp=%h",
                         $time, got.locked, got.err, got.errc, got.wordc, got.exp,
                         e.locked, e.err, e.errc, e.wordc, e.exp);
            end
        end
    endtask

    task automatic sendWord(input logic [7:0] d);
        step(1'b0, 1'b1, 1'b0, d);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 8'h5A);
    endtask

    task automatic arm();
        step(1'b1, 1'b0, 1'b0, 8'h00);
        errPulses = 0;
    endtask

    task automatic test_reset();
        repeat (3) step(1'b0, 1'b0, 1'b1, 8'h00);
        checks++;
        if ({a_locked, a_err, a_err_cnt, a_word_cnt, a_expected} !== 42'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %h want 0", {a_locked, a_err, a_err_cnt, a_word_cnt, a_expected});
        end
    endtask

    task automatic test_count(input bit gaps);
        arm();
        for (int i = 0; i < 10; i++) begin
            sendWord(8'(i));
            if (i == 0) begin
                checks++;
                if (a_locked !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL lock_after_word0 got %b want 1", a_locked);
                end
            end
            if (gaps) idle();
        end
        checks++;
        if (a_err_cnt !== 16'd0 || a_word_cnt !== 16'd10 || a_expected !== 8'd10 || errPulses != 0) begin
            errors++;
            $display("[TB] FAIL count gaps=%0d got errc=%0d wordc=%0d exp=%h pulses=%0d want 0 10 0a 0",
                     gaps, a_err_cnt, a_word_cnt, a_expected, errPulses);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] words [5];
        words = '{8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01};
        arm();
        foreach (words[k]) sendWord(words[k]);
        checks++;
        if (a_err_cnt !== 16'd0 || a_expected !== 8'h02) begin
            errors++;
            $display("[TB] FAIL wrap got errc=%0d exp=%h want 0 02", a_err_cnt, a_expected);
        end
    endtask

    task automatic test_glitch();
        logic [7:0] words [6];
        words = '{8'd0, 8'd1, 8'd2, 8'd7, 8'd8, 8'd9};
        arm();
        foreach (words[k]) begin
            sendWord(words[k]);
            checks++;
            if (a_err !== (k == 3)) begin
                errors++;
                $display("[TB] FAIL glitch_pulse word%0d got %b want %b", k, a_err, (k == 3));
            end
        end
        checks++;
        if (a_err_cnt !== 16'd1 || a_locked !== 1'b1 || a_expected !== 8'h0A) begin
            errors++;
            $display("[TB] FAIL glitch got errc=%0d locked=%b exp=%h want 1 1 0a", a_err_cnt, a_locked, a_expected);
        end
    endtask

    task automatic test_loss();
        logic [7:0] words [6];
        words = '{8'd0, 8'd1, 8'd5, 8'd5, 8'd5, 8'd6};
        arm();
        foreach (words[k]) begin
            sendWord(words[k]);
            if (k == 4) begin
                checks++;
                if (a_locked !== 1'b0 || a_err_cnt !== 16'd3) begin
                    errors++;
                    $display("[TB] FAIL loss_drop got locked=%b errc=%0d want 0 3", a_locked, a_err_cnt);
                end
            end
        end
        checks++;
`ifdef SEQ_CHK_AUTO_RESYNC_EN
        if (a_locked !== 1'b1 || a_expected !== 8'h07 || a_err_cnt !== 16'd3) begin
            errors++;
            $display("[TB] FAIL loss_relock got locked=%b exp=%h errc=%0d want 1 07 3", a_locked, a_expected, a_err_cnt);
        end
`else
        if (a_locked !== 1'b0 || a_word_cnt !== 16'd6 || a_err_cnt !== 16'd3) begin
            errors++;
            $display("[TB] FAIL loss_sticky got locked=%b wordc=%0d errc=%0d want 0 6 3", a_locked, a_word_cnt, a_err_cnt);
        end
`endif
        repeat (3) idle();
    endtask

    task automatic test_reset_midrun();
        arm();
        sendWord(8'd0);
        sendWord(8'd1);
        sendWord(8'd2);
        step(1'b0, 1'b1, 1'b1, 8'd3);
        sendWord(8'd3);
        sendWord(8'd4);
        checks++;
        if ({a_locked, a_err, a_err_cnt, a_word_cnt, a_expected} !== 42'd0) begin
            errors++;
            $display("[TB] FAIL midrun_reset got %h want 0", {a_locked, a_err, a_err_cnt, a_word_cnt, a_expected});
        end
        step(1'b1, 1'b1, 1'b0, 8'd9);
        sendWord(8'd3);
        sendWord(8'd4);
        checks++;
        if (a_locked !== 1'b1 || a_expected !== 8'h05 || a_word_cnt !== 16'd2) begin
            errors++;
            $display("[TB] FAIL midrun_rearm got locked=%b exp=%h wordc=%0d want 1 05 2", a_locked, a_expected, a_word_cnt);
        end
    endtask

    task automatic test_saturation();
        arm();
        for (int i = 0; i < 20; i++) sendWord((i % 2 == 0) ? 8'h00 : 8'h80);
        checks++;
        if (b_err_cnt !== 4'hF || b_word_cnt !== 4'hF || b_locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL saturation got errc=%h wordc=%h locked=%b want f f 1", b_err_cnt, b_word_cnt, b_locked);
        end
    endtask

    initial begin
        rst = 1'b1;
        i_start = 1'b0;
        i_valid = 1'b0;
        i_data = '0;
        m = '0;
        mMiss = 0;
        mState = IDLE;
        test_reset();
        test_count(1'b0);
        test_wrap();
        test_glitch();
        test_loss();
        test_reset_midrun();
        test_saturation();
        test_count(1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
